// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave bridging 32-bit bus words onto a 16-bit asynchronous SRAM/PSRAM,
// splitting each access into two half-word cycles with programmable strobe width.
module wb_sram_ctrl #(
    parameter int unsigned adr_width   = 23,
    parameter int unsigned wait_cycles = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    output logic                 wb_ack_o,
    output logic [adr_width-1:0] sram_adr,
    inout  wire  [15:0]          sram_dq,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n
);

    localparam int unsigned CW = (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(wait_cycles - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, ACK} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 half;
    logic                 abort;
    logic [adr_width-2:0] adr_q;
    logic [31:0]          dat_q;
    logic [31:0]          rdata;
    logic [3:0]           sel_q;
    logic                 we_q;
    logic [15:0]          dq_out;
    logic                 dq_oe;

    logic [adr_width-2:0] src_adr;
    logic [31:0]          src_dat;
    logic [3:0]           src_sel;
    logic                 src_we;
    logic                 need0;
    logic                 need1;
    logic                 nxt_half;
    logic [adr_width-1:0] nxt_adr;
    logic                 nxt_ub;
    logic                 nxt_lb;
    logic [15:0]          nxt_dat;
    logic                 unused_adr;

    assign unused_adr = ^{wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};
    assign sram_dq    = dq_oe ? dq_out : {16{1'bz}};

    // In IDLE the half setup is derived from the live bus so SETUP starts the cycle after the request.
    always_comb begin
        if (state == IDLE) begin
            src_adr = wb_adr_i[adr_width:2];
            src_dat = wb_dat_i;
            src_sel = wb_sel_i;
            src_we  = wb_we_i;
        end else begin
            src_adr = adr_q;
            src_dat = dat_q;
            src_sel = sel_q;
            src_we  = we_q;
        end
        need0    = ~src_we | (|src_sel[3:2]);
        need1    = ~src_we | (|src_sel[1:0]);
        nxt_half = (state == IDLE) ? ~need0 : 1'b1;
        nxt_adr  = {src_adr, nxt_half};
        nxt_ub   = src_we & ~(nxt_half ? src_sel[1] : src_sel[3]);
        nxt_lb   = src_we & ~(nxt_half ? src_sel[0] : src_sel[2]);
        nxt_dat  = nxt_half ? src_dat[15:0] : src_dat[31:16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            half      <= 1'b0;
            abort     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rdata     <= '0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            sram_adr  <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_ack_o <= 1'b0;
                    wb_dat_o <= '0;
                    if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                        adr_q <= src_adr;
                        dat_q <= src_dat;
                        sel_q <= src_sel;
                        we_q  <= src_we;
                        rdata <= '0;
                        abort <= 1'b0;
                        if (need0 || need1) begin
                            state     <= SETUP;
                            half      <= nxt_half;
                            sram_adr  <= nxt_adr;
                            sram_ce_n <= 1'b0;
                            sram_ub_n <= nxt_ub;
                            sram_lb_n <= nxt_lb;
                            dq_out    <= nxt_dat;
                            dq_oe     <= src_we;
                        end else begin
                            state    <= ACK;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= '0;
                        end
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    cnt       <= '0;
                    sram_oe_n <= we_q;
                    sram_we_n <= ~we_q;
                    if (!wb_cyc_i) abort <= 1'b1;
                end
                STROBE: begin
                    if (!wb_cyc_i) abort <= 1'b1;
                    if (cnt == LAST) begin
                        state     <= RECOVER;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (!we_q) begin
                            if (half) rdata[15:0]  <= sram_dq;
                            else      rdata[31:16] <= sram_dq;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    // A dropped cycle only takes effect here, so a started strobe always runs full width.
                    if (abort || !wb_cyc_i) begin
                        state     <= IDLE;
                        sram_ce_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        dq_oe     <= 1'b0;
                    end else if (!half && need1) begin
                        state     <= SETUP;
                        half      <= 1'b1;
                        sram_adr  <= nxt_adr;
                        sram_ub_n <= nxt_ub;
                        sram_lb_n <= nxt_lb;
                        dq_out    <= nxt_dat;
                        dq_oe     <= we_q;
                    end else begin
                        state     <= ACK;
                        wb_ack_o  <= 1'b1;
                        wb_dat_o  <= rdata;
                        sram_ce_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        dq_oe     <= 1'b0;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    wb_ack_o <= 1'b0;
                    wb_dat_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
- Wishbone classic slave that bridges the 32-bit LM32 data/instruction bus to the board's 16-bit asynchronous SRAM/PSRAM (Nexys4 cellular RAM, async mode).
- Attaches as the sram0 slave on conbus; consumes the sram0_* wishbone signals and drives the external memory pins.
- Each 32-bit access is split into two 16-bit half-accesses, with programmable wait states.

Parameters:
- adr_width, 23, SRAM half-word address width; byte window is 2^(adr_width+1).
- wait_cycles, 7, cycles the OE_n/WE_n strobe is held low per half-access; must be ≥1 (7 = 70 ns at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  byte address; only bits [adr_width:2] are used.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o=1.
- wb_sel_i  in  4  byte selects, big-endian: sel[3] selects [31:24].
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  single-cycle acknowledge.
- sram_adr  out  adr_width  half-word address.
- sram_dq  inout  16  data bus; tristated unless this block is writing.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_ub_n  out  1  upper-byte enable, active low.
- sram_lb_n  out  1  lower-byte enable, active low.

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Reset values (one edge after reset=1, from any state):
  - wb_ack_o=0, wb_dat_o=0, sram_adr=0.
  - sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n and sram_lb_n all 1.
  - sram_dq tristated; FSM=IDLE; counter=0.
  - A transfer in progress when reset is asserted is abandoned immediately, with no ack.
- Address and byte mapping:
  - Half 0 (H=0): sram_adr={wb_adr_i[adr_width:2],1'b0}; carries [31:16]; ub_n=~sel[3], lb_n=~sel[2].
  - Half 1 (H=1): sram_adr={wb_adr_i[adr_width:2],1'b1}; carries [15:0]; ub_n=~sel[1], lb_n=~sel[0].
- Half selection:
  - Read: both halves are always accessed, with ub_n=lb_n=0.
  - Write: a half whose two sel bits are both 0 is skipped.
  - Write with sel=0: no SRAM activity; ack only.
- FSM states: IDLE, SETUP, STROBE, RECOVER, ACK.
- IDLE:
  - On wb_cyc_i & wb_stb_i & ~wb_ack_o, latch address, data, sel and we.
  - Go to SETUP for the first needed half, or straight to ACK if no half is needed.
- SETUP (1 cycle):
  - ce_n=0; address and byte enables valid; oe_n=we_n=1.
  - For a write, sram_dq is driven with the half's data.
- STROBE (wait_cycles cycles):
  - oe_n=0 for a read, we_n=0 for a write.
  - A read captures sram_dq into the matching half of the read register on the last STROBE cycle.
- RECOVER (1 cycle):
  - Strobes return to 1; ce_n=0; address and write data held.
  - Then go to SETUP for the next needed half, else ACK.
- ACK (1 cycle):
  - wb_ack_o=1 and wb_dat_o=read register; sram_ce_n=1; bus tristated.
  - Next state is IDLE. A new request can be accepted no earlier than the cycle after ACK.
- wb_dat_o is 0 outside ACK.
- Latency: request sampled in IDLE in cycle 0; each half occupies wait_cycles+2 cycles.
  - Read: ack in cycle 2*wait_cycles+5 (19 at default).
  - Single-half write: ack in cycle wait_cycles+3 (10 at default).
  - sel=0 write: ack in cycle 1.
- Abort: if wb_cyc_i drops mid-transfer, the current half finishes through RECOVER, then the FSM goes to IDLE with no ack. This guarantees WE_n never glitches short.
- Stb/cyc held high after ack does not start a second access in the ACK cycle itself.
- sram_dq is never driven while oe_n=0, and oe_n and we_n are never low in the same cycle.

Test Plan:
- Full-word write 0x0000_0010 ← 0xDEADBEEF, sel=F, then read the same address:
  - Write: SRAM model holds half-addr 8 = 0xDEAD, half-addr 9 = 0xBEEF.
  - Read: ack in cycle 19 with wb_dat_o=0xDEADBEEF; ack high exactly 1 cycle.
- Byte write sel=4'b0100, data 0x00AB0000, to word 0x10 holding 0xDEADBEEF:
  - Only half 0 is accessed, with ub_n=1 and lb_n=0.
  - Ack in cycle 10; a subsequent read returns 0xDEABBEEF.
- Write with sel=0: ack in cycle 1; ce_n stays 1 throughout; SRAM contents unchanged.
- STROBE width with wait_cycles=3 (instance override): oe_n is low exactly 3 consecutive cycles per half; read ack in cycle 11.
- Reset asserted during STROBE of half 0 of a write: one edge later, we_n=ce_n=1, dq is tristated, and no ack is ever issued; the next read works normally.
- cyc dropped during STROBE of half 0:
  - we_n completes its full wait_cycles-wide pulse, then RECOVER, then IDLE.
  - Half 1 is never accessed and no ack is issued.
